erx_deser: RTL and testbench

- Parametrised receive deserializer and packet assembler; next generation of the elink RX IO packet path.
- Sits after the IDDR/input registers in the rx_lclk domain and consumes one IW-bit word per cycle, qualified by rx_frame.
- Assembles 112-bit transactions into PW-bit emesh packets. Supports burst continuation with automatic dstaddr increment and detects truncated frames.
- Buffers packets in a DEPTH-entry FIFO with wait back-pressure and drives an early stall flag toward the rx wait pins.

---
 rtl/erx_deser.sv | 194 +++++++++++++++++++
 tb/tb_erx_deser.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/erx_deser.sv
// ============================================================================
// erx_deser : elink RX deserializer, emesh packet assembler and output FIFO.
// Optional statistics counters under ERX_DESER_STATS_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module erx_deser #(
  parameter int IW    = 16,
  parameter int PW    = 104,
  parameter int DEPTH = 4,
  parameter int SLACK = 2
`ifdef ERX_DESER_STATS_EN
  ,
  parameter int CW    = 16
`endif
) (
  input  logic          rx_lclk,
  input  logic          rx_reset,
  input  logic          rx_frame,
  input  logic [IW-1:0] rx_word,
  output logic          rx_access,
  output logic [PW-1:0] rx_packet,
  output logic          rx_burst,
  input  logic          rx_wait,
  output logic          rx_stall,
  output logic          err_frame,
  output logic          err_overflow
`ifdef ERX_DESER_STATS_EN
  ,
  output logic [CW-1:0] stat_pkt_count,
  output logic [CW-1:0] stat_err_count
`endif
);

  localparam int NW = 112 / IW;
  localparam int BW = 64 / IW;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_AT = (AW+1)'(DEPTH - SLACK);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    HEAD  = 2'd2,
    BURST = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  // Bytes B1..B13 of the current transaction; B0 carries nothing and is not kept.
  logic [103:0]  buffer;
  logic [103:0]  merged;
  logic [3:0]    base;
  int            pos;
  logic [31:0]   dst;
  logic [31:0]   new_dst;
  logic [PW-1:0] new_pkt;
  logic          push_vld;
  logic          push_burst;
  logic [PW-1:0] push_pkt;

  always_comb begin
    pos    = 0;
    base   = (state == BURST) ? 4'(6 + cnt * (IW / 8)) : 4'(cnt * (IW / 8));
    merged = buffer;
    for (int j = 0; j < IW / 8; j++) begin
      pos = int'(base) + j;
      if (pos != 0) merged[(pos - 1) * 8 +: 8] = rx_word[j * 8 +: 8];
    end
  end

  assign new_dst = (state == BURST) ? dst + 32'd8
                 : {merged[3:0], merged[15:8], merged[23:16], merged[31:24], merged[39:36]};
  assign new_pkt = {merged[79:72], merged[87:80], merged[95:88], merged[103:96],
                    merged[47:40], merged[55:48], merged[63:56], merged[71:64],
                    new_dst, merged[7:4], merged[35:32]};

  always_ff @(posedge rx_lclk or posedge rx_reset) begin
    if (rx_reset) begin
      state      <= SYNC;
      cnt        <= '0;
      buffer     <= '0;
      dst        <= '0;
      push_vld   <= 1'b0;
      push_burst <= 1'b0;
      push_pkt   <= '0;
      err_frame  <= 1'b0;
    end else begin
      push_vld  <= 1'b0;
      err_frame <= 1'b0;
      case (state)
        SYNC: if (!rx_frame) state <= IDLE;
        IDLE: if (rx_frame) begin
          buffer <= merged;
          cnt    <= 4'd1;
          state  <= HEAD;
        end
        HEAD: begin
          if (!rx_frame) begin
            err_frame <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else if (cnt == 4'(NW - 1)) begin
            buffer     <= merged;
            push_vld   <= 1'b1;
            push_burst <= 1'b0;
            push_pkt   <= new_pkt;
            dst        <= new_dst;
            cnt        <= '0;
            state      <= BURST;
          end else begin
            buffer <= merged;
            cnt    <= cnt + 4'd1;
          end
        end
        BURST: begin
          // A drop exactly on a beat boundary is the normal end of a burst.
          if (!rx_frame) begin
            err_frame <= (cnt != 4'd0);
            cnt       <= '0;
            state     <= IDLE;
          end else if (cnt == 4'(BW - 1)) begin
            buffer     <= merged;
            push_vld   <= 1'b1;
            push_burst <= 1'b1;
            push_pkt   <= new_pkt;
            dst        <= new_dst;
            cnt        <= '0;
          end else begin
            buffer <= merged;
            cnt    <= cnt + 4'd1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  logic [PW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;

  assign rx_access  = (count != '0);
  assign pop        = rx_access & ~rx_wait;
  assign full       = (count == FULL_CNT);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept     = push_vld & (~full | pop);
  assign drop       = push_vld & full & ~pop;
  assign count_next = count + (AW+1)'(accept) - (AW+1)'(pop);
  assign rx_packet  = rx_access ? mem[rd_ptr][PW-1:0] : '0;
  assign rx_burst   = rx_access ? mem[rd_ptr][PW] : 1'b0;

  always_ff @(posedge rx_lclk) begin
    if (accept) mem[wr_ptr] <= {push_burst, push_pkt};
  end

`ifdef ERX_DESER_STATS_EN
  logic [CW:0] err_sum;
  assign err_sum = {1'b0, stat_err_count} + (CW+1)'(err_frame) + (CW+1)'(err_overflow);
`endif

  always_ff @(posedge rx_lclk or posedge rx_reset) begin
    if (rx_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rx_stall     <= 1'b0;
      err_overflow <= 1'b0;
`ifdef ERX_DESER_STATS_EN
      stat_pkt_count <= '0;
      stat_err_count <= '0;
`endif
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count        <= count_next;
      rx_stall     <= (count_next >= STALL_AT);
      err_overflow <= drop;
`ifdef ERX_DESER_STATS_EN
      if (accept && stat_pkt_count != '1) stat_pkt_count <= stat_pkt_count + 1'b1;
      stat_err_count <= err_sum[CW] ? '1 : err_sum[CW-1:0];
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_erx_deser.sv
// Randomized self-checking bench for erx_deser: serializes transactions byte by
// byte and scores popped packets against a field-level expected queue.
`default_nettype none

module tb_erx_deser;

  localparam int IW    = 16;
  localparam int PW    = 104;
  localparam int DEPTH = 4;
  localparam int SLACK = 2;
  localparam int NW    = 112 / IW;
  localparam int BW    = 64 / IW;
`ifdef ERX_DESER_STATS_EN
  localparam int CW    = 4;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          frame;
  logic [IW-1:0] word;
  logic          access;
  logic [PW-1:0] packet;
  logic          burst;
  logic          wait_in;
  logic          stall;
  logic          errf;
  logic          ovf;
`ifdef ERX_DESER_STATS_EN
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] err_cnt;
`endif

  erx_deser #(
    .IW(IW), .PW(PW), .DEPTH(DEPTH), .SLACK(SLACK)
`ifdef ERX_DESER_STATS_EN
    , .CW(CW)
`endif
  ) dut (
    .rx_lclk(clk), .rx_reset(rst), .rx_frame(frame), .rx_word(word),
    .rx_access(access), .rx_packet(packet), .rx_burst(burst), .rx_wait(wait_in),
    .rx_stall(stall), .err_frame(errf), .err_overflow(ovf)
`ifdef ERX_DESER_STATS_EN
    , .stat_pkt_count(pkt_cnt), .stat_err_count(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_errf   = 0;
  int n_ovf    = 0;
  int n_pops   = 0;
  int exp_errf = 0;
  int exp_ovf  = 0;
  int exp_good = 0;
  logic [PW:0] exp_q [$];
  logic [PW:0] mon_e;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [PW-1:0] pack(input logic a, input logic w, input logic [1:0] dm,
                                         input logic [3:0] ctrl, input logic [31:0] dst,
                                         input logic [31:0] data, input logic [31:0] src);
    return {src, data, dst, ctrl, dm, w, a};
  endfunction

  // FIFO model: while the consumer holds wait, only DEPTH packets fit.
  task automatic model_push(input logic [PW-1:0] p, input logic b);
    if (wait_in && exp_q.size() >= DEPTH) exp_ovf++;
    else begin
      exp_q.push_back({b, p});
      exp_good++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (errf) n_errf++;
      if (ovf)  n_ovf++;
      if (access && !wait_in) begin
        n_pops++;
        if (exp_q.size() == 0) check("unexpected_pkt", 128'(packet), 128'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("packet", 128'(packet), 128'(mon_e[PW-1:0]));
          check("burst_flag", 128'(burst), 128'(mon_e[PW]));
        end
      end
    end
  end

  task automatic drive_word(input logic [IW-1:0] w);
    frame = 1'b1;
    word  = w;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    frame = 1'b0;
    word  = IW'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    check("drain_left", 128'(exp_q.size()), 128'd0);
  endtask

  // head_cut: words sent before the frame drops mid-head (0 = complete head).
  // tail_cut: words of a partial beat after the full beats (0 = clean end).
  task automatic send_txn(input logic [3:0] ctrl, input logic [31:0] dst, input logic [1:0] dm,
                          input logic w, input logic a, input logic [31:0] data,
                          input logic [31:0] src, input int beats, input int head_cut,
                          input int tail_cut);
    logic [7:0]  b  [14];
    logic [7:0]  bb [8];
    logic [31:0] addr;
    logic [31:0] d2;
    logic [31:0] s2;
    b[0] = 8'($urandom);
    b[1] = {ctrl, dst[31:28]};
    b[2] = dst[27:20]; b[3] = dst[19:12]; b[4] = dst[11:4];
    b[5] = {dst[3:0], dm, w, a};
    for (int i = 0; i < 4; i++) begin
      b[6 + i]  = data[31 - 8 * i -: 8];
      b[10 + i] = src[31 - 8 * i -: 8];
    end
    if (head_cut > 0) begin
      for (int k = 0; k < head_cut; k++) drive_word({b[2 * k + 1], b[2 * k]});
      exp_errf++;
    end else begin
      model_push(pack(a, w, dm, ctrl, dst, data, src), 1'b0);
      for (int k = 0; k < NW; k++) drive_word({b[2 * k + 1], b[2 * k]});
      addr = dst;
      for (int n = 0; n < beats + (tail_cut > 0 ? 1 : 0); n++) begin
        d2 = $urandom;
        s2 = $urandom;
        for (int i = 0; i < 4; i++) begin
          bb[i]     = d2[31 - 8 * i -: 8];
          bb[4 + i] = s2[31 - 8 * i -: 8];
        end
        if (n < beats) begin
          addr = addr + 32'd8;
          model_push(pack(a, w, dm, ctrl, addr, d2, s2), 1'b1);
          for (int j = 0; j < BW; j++) drive_word({bb[2 * j + 1], bb[2 * j]});
        end else begin
          for (int j = 0; j < tail_cut; j++) drive_word({bb[2 * j + 1], bb[2 * j]});
          exp_errf++;
        end
      end
    end
    idle(1);
  endtask

  task automatic send_random(input int beats, input int head_cut, input int tail_cut);
    send_txn(4'($urandom), $urandom, 2'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, beats, head_cut, tail_cut);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [IW-1:0] dir_words [11];
  int pops0;
  int r;

  initial begin
    dir_words = '{16'h0800, 16'h0100, 16'h4B23, 16'hADDE, 16'hEFBE, 16'h0000, 16'hC000,
                  16'h3412, 16'h7856, 16'h0000, 16'hD000};
    rst = 1'b1; frame = 1'b0; word = '0; wait_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_access", 128'(access), 128'd0);
    check("rst_packet", 128'(packet), 128'd0);
    check("rst_burst",  128'(burst), 128'd0);
    check("rst_stall",  128'(stall), 128'd0);
    check("rst_errf",   128'(errf), 128'd0);
    check("rst_ovf",    128'(ovf), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Single transaction, literal word stream, with push latency.
    exp_q.push_back({1'b0, pack(1'b1, 1'b1, 2'd2, 4'h0, 32'h80001234, 32'hDEADBEEF, 32'h000000C0)});
    exp_good++;
    for (int k = 0; k < 7; k++) drive_word(dir_words[k]);
    frame = 1'b0;
    @(negedge clk);
    check("latency_early", 128'(access), 128'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("latency_access", 128'(access), 128'd1);
    @(posedge clk); #1;
    idle(2);
    drain();

    // Burst continuation ending cleanly on the beat boundary.
    exp_q.push_back({1'b0, pack(1'b1, 1'b1, 2'd2, 4'h0, 32'h80001234, 32'hDEADBEEF, 32'h000000C0)});
    exp_q.push_back({1'b1, pack(1'b1, 1'b1, 2'd2, 4'h0, 32'h8000123C, 32'h12345678, 32'h000000D0)});
    exp_good += 2;
    for (int k = 0; k < 11; k++) drive_word(dir_words[k]);
    idle(4);
    drain();
    check("burst_no_errf", 128'(n_errf), 128'(exp_errf));

    // Truncated head, then a good frame.
    pops0 = n_pops;
    send_random(0, 3, 0);
    idle(3);
    check("trunc_errf", 128'(n_errf), 128'(exp_errf));
    check("trunc_no_pkt", 128'(n_pops - pops0), 128'd0);
    send_random(0, 0, 0);
    idle(3);
    drain();

    // Dstaddr wrap across a burst beat.
    send_txn(4'hA, 32'hFFFF_FFFC, 2'd3, 1'b0, 1'b1, $urandom, $urandom, 2, 0, 0);
    idle(3);
    drain();

    // Randomized transactions, bursts and truncations.
    for (int t = 0; t < 30; t++) begin
      r = int'($urandom_range(0, 5));
      if (r == 0)      send_random(0, int'($urandom_range(1, NW - 1)), 0);
      else if (r == 1) send_random(int'($urandom_range(0, 3)), 0, int'($urandom_range(1, BW - 1)));
      else             send_random(int'($urandom_range(0, 3)), 0, 0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(4);
    drain();
    check("rand_errf", 128'(n_errf), 128'(exp_errf));

    // Back-pressure: five transactions into a four-entry FIFO.
    wait_in = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      send_random(0, 0, 0);
      idle(3);
      check("stall", 128'(stall), 128'((DEPTH - (t < DEPTH ? t : DEPTH)) <= SLACK));
    end
    check("bp_ovf", 128'(n_ovf), 128'(exp_ovf));
    check("bp_access", 128'(access), 128'd1);
    wait_in = 1'b0;
    idle(8);
    drain();
    check("bp_stall_clear", 128'(stall), 128'd0);

    // Reset in the middle of a frame, released while the frame is still up.
    pops0 = n_pops;
    for (int k = 0; k < 4; k++) drive_word(IW'($urandom));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_access", 128'(access), 128'd0);
    check("midrst_errf", 128'(errf), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) drive_word(IW'($urandom));
    idle(6);
    check("midrst_no_pkt", 128'(n_pops - pops0), 128'd0);
    check("midrst_errf_total", 128'(n_errf), 128'(exp_errf));
    send_random(1, 0, 0);
    idle(4);
    drain();

`ifdef ERX_DESER_STATS_EN
    check("stat_pkt", 128'(pkt_cnt), 128'(exp_good > 15 ? 15 : exp_good));
    check("stat_err", 128'(err_cnt), 128'((exp_errf + exp_ovf) > 15 ? 15 : (exp_errf + exp_ovf)));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
